// File: rtl/matrix_op_sequencer.sv
// Command sequencer for the 5x5 int8 alu matrix datapath: loads A/B row by row,
// fires the alu, waits for done (with timeout) and streams the result rows back out.
module matrix_op_sequencer #(
    parameter int N_MAX   = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [2:0]                        cmd_opcode,
    input  logic [DATA_W-1:0]                 cmd_scalar,
    input  logic [2:0]                        cmd_size,
    input  logic                              ld_valid,
    output logic                              ld_ready,
    input  logic [N_MAX*DATA_W-1:0]           ld_data,
    output logic [N_MAX*N_MAX*DATA_W-1:0]     alu_a_flat,
    output logic [N_MAX*N_MAX*DATA_W-1:0]     alu_b_flat,
    output logic [DATA_W-1:0]                 alu_f,
    output logic [2:0]                        alu_opcode,
    input  logic [N_MAX*N_MAX*DATA_W-1:0]     alu_c_flat,
    input  logic                              alu_overflow,
    input  logic                              alu_done,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [N_MAX*DATA_W-1:0]           res_data,
    output logic                              res_last,
    output logic                              res_overflow,
    output logic                              res_err,
    output logic                              busy
);
    localparam int ROW_W = N_MAX * DATA_W;
    localparam int MAT_W = N_MAX * ROW_W;
    localparam int WC_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WAIT, S_OUT, S_ERR
    } state_t;

    state_t            r_state;
    logic [2:0]        r_opcode;
    logic [DATA_W-1:0] r_scalar;
    logic [2:0]        r_size;
    logic [2:0]        r_row_cnt;
    logic [2:0]        r_out_cnt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [MAT_W-1:0]  r_c;

    logic             w_cmd_hs;
    logic             w_ld_hs;
    logic             w_res_hs;
    logic             w_bad_cmd;
    logic             w_need_b;
    logic             w_row_last;
    logic [2:0]       w_out_nxt;
    logic [ROW_W-1:0] w_ld_row;

    // Columns at or beyond the active size never reach the operand registers.
    function automatic logic [ROW_W-1:0] mask_row(input logic [ROW_W-1:0] d, input logic [2:0] n);
        logic [ROW_W-1:0] m;
        m = d;
        for (int c = 0; c < N_MAX; c++) begin
            if (c >= int'(n)) m[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        end
        return m;
    endfunction

    assign cmd_ready  = (r_state == S_IDLE) & ~rst;
    assign ld_ready   = (r_state == S_LOAD_A) | (r_state == S_LOAD_B);
    assign w_cmd_hs   = cmd_valid & cmd_ready;
    assign w_ld_hs    = ld_valid & ld_ready;
    assign w_res_hs   = res_valid & res_ready;
    assign w_bad_cmd  = (cmd_opcode == 3'b000) | (cmd_size == 3'd0) | (int'(cmd_size) > N_MAX);
    assign w_need_b   = (r_opcode == 3'b001) | (r_opcode == 3'b010) | (r_opcode == 3'b011);
    assign w_row_last = (r_row_cnt == r_size - 3'd1);
    assign w_out_nxt  = r_out_cnt + 3'd1;
    assign w_ld_row   = mask_row(ld_data, r_size);

    // Sequencer FSM; every output it drives is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= 3'b000;
            r_scalar     <= {DATA_W{1'b0}};
            r_size       <= 3'd0;
            r_row_cnt    <= 3'd0;
            r_out_cnt    <= 3'd0;
            r_wait_cnt   <= {WC_W{1'b0}};
            r_c          <= {MAT_W{1'b0}};
            alu_a_flat   <= {MAT_W{1'b0}};
            alu_b_flat   <= {MAT_W{1'b0}};
            alu_f        <= {DATA_W{1'b0}};
            alu_opcode   <= 3'b000;
            res_valid    <= 1'b0;
            res_data     <= {ROW_W{1'b0}};
            res_last     <= 1'b0;
            res_overflow <= 1'b0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_opcode   <= cmd_opcode;
                        r_scalar   <= cmd_scalar;
                        r_size     <= cmd_size;
                        r_row_cnt  <= 3'd0;
                        alu_a_flat <= {MAT_W{1'b0}};
                        alu_b_flat <= {MAT_W{1'b0}};
                        busy       <= 1'b1;
                        if (w_bad_cmd) begin
                            r_state      <= S_ERR;
                            res_valid    <= 1'b1;
                            res_data     <= {ROW_W{1'b0}};
                            res_last     <= 1'b1;
                            res_err      <= 1'b1;
                            res_overflow <= 1'b0;
                        end else begin
                            r_state <= S_LOAD_A;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (w_ld_hs) begin
                        if (r_state == S_LOAD_A) alu_a_flat[int'(r_row_cnt)*ROW_W +: ROW_W] <= w_ld_row;
                        else                     alu_b_flat[int'(r_row_cnt)*ROW_W +: ROW_W] <= w_ld_row;
                        if (w_row_last) begin
                            r_row_cnt <= 3'd0;
                            if ((r_state == S_LOAD_A) && w_need_b) begin
                                r_state <= S_LOAD_B;
                            end else begin
                                r_state    <= S_EXEC;
                                alu_opcode <= r_opcode;
                                alu_f      <= r_scalar;
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                S_EXEC: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= {WC_W{1'b0}};
                end
                S_WAIT: begin
                    // A done seen in the first WAIT cycle may belong to the previous op.
                    if ((r_wait_cnt != {WC_W{1'b0}}) && alu_done) begin
                        r_c          <= alu_c_flat;
                        res_overflow <= alu_overflow;
                        res_err      <= 1'b0;
                        res_data     <= alu_c_flat[ROW_W-1:0];
                        alu_opcode   <= 3'b000;
                        alu_f        <= {DATA_W{1'b0}};
                        res_valid    <= 1'b1;
                        res_last     <= (r_size == 3'd1);
                        r_out_cnt    <= 3'd0;
                        r_state      <= S_OUT;
                    end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
                        r_c          <= {MAT_W{1'b0}};
                        res_overflow <= 1'b0;
                        res_err      <= 1'b1;
                        res_data     <= {ROW_W{1'b0}};
                        alu_opcode   <= 3'b000;
                        alu_f        <= {DATA_W{1'b0}};
                        res_valid    <= 1'b1;
                        res_last     <= (r_size == 3'd1);
                        r_out_cnt    <= 3'd0;
                        r_state      <= S_OUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + {{(WC_W-1){1'b0}}, 1'b1};
                    end
                end
                S_OUT, S_ERR: begin
                    if (w_res_hs) begin
                        if (res_last) begin
                            res_valid    <= 1'b0;
                            res_last     <= 1'b0;
                            res_data     <= {ROW_W{1'b0}};
                            res_err      <= 1'b0;
                            res_overflow <= 1'b0;
                            busy         <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_out_cnt <= w_out_nxt;
                            res_data  <= r_c[int'(w_out_nxt)*ROW_W +: ROW_W];
                            res_last  <= (w_out_nxt == r_size - 3'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench for matrix_op_sequencer: a scripted alu model answers each op with
// a hand-computed C matrix; a negedge monitor pops expected result beats.
module tb_matrix_op_sequencer;
    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_opcode, cmd_size;
    logic [7:0]   cmd_scalar;
    logic         ld_valid, ld_ready;
    logic [39:0]  ld_data;
    logic [199:0] alu_a_flat, alu_b_flat, alu_c_flat;
    logic [7:0]   alu_f;
    logic [2:0]   alu_opcode;
    logic         alu_overflow, alu_done;
    logic         res_valid, res_ready, res_last, res_overflow, res_err, busy;
    logic [39:0]  res_data;

    typedef struct packed {
        logic        err;
        logic        ovf;
        logic        last;
        logic [39:0] data;
    } beat_t;

    beat_t        sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [199:0] exp_a, exp_b;
    logic [7:0]   exp_f;
    logic [2:0]   exp_op;
    int           exp_act;
    logic         alu_hang;
    int           act_cnt = 0;
    logic         op_bad = 1'b0;
    logic         stall_prev = 1'b0;
    logic [39:0]  prev_data;
    logic         prev_last;

    always #5 clk = ~clk;

    matrix_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_scalar(cmd_scalar), .cmd_size(cmd_size),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .alu_a_flat(alu_a_flat), .alu_b_flat(alu_b_flat), .alu_f(alu_f),
        .alu_opcode(alu_opcode), .alu_c_flat(alu_c_flat), .alu_overflow(alu_overflow),
        .alu_done(alu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .res_overflow(res_overflow), .res_err(res_err),
        .busy(busy)
    );

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [39:0] d, input logic last, input logic ovf, input logic err);
        sb.push_back(beat_t'({err, ovf, last, d}));
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] f, input logic [2:0] sz);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_scalar = f; cmd_size = sz;
        for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge clk); #1; end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load_row(input logic [39:0] d);
        ld_valid = 1'b1; ld_data = d;
        for (int i = 0; i < 50 && !ld_ready; i++) begin @(posedge clk); #1; end
        check("ld_accept", ld_ready, 1'b1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 300; i++) begin
            if (!busy && sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("frame_done", {busy, sb.size() != 0}, 2'b00);
        @(posedge clk); #1;
    endtask

    // Scripted alu: done from the first active cycle unless hung; checks operands and hold time.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            act_cnt = 0; op_bad = 1'b0; alu_done = 1'b0;
        end else if (alu_opcode != 3'b000) begin
            if (act_cnt == 0) begin
                check("alu_a", alu_a_flat, exp_a);
                check("alu_b", alu_b_flat, exp_b);
            end
            if (alu_opcode != exp_op || alu_f != exp_f) op_bad = 1'b1;
            act_cnt++;
            alu_done = !alu_hang;
        end else begin
            if (act_cnt != 0) begin
                check("alu_active_cycles", act_cnt, exp_act);
                check("alu_op_f_hold", op_bad, 1'b0);
            end
            act_cnt = 0; op_bad = 1'b0; alu_done = 1'b0;
        end
    end

    // Result monitor: pops the scoreboard on each handshake and checks hold during stalls.
    always @(negedge clk) begin
        beat_t e;
        if (rst || !res_valid) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("res_hold", {res_last, res_data}, {prev_last, prev_data});
            if (res_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_beat actual=%h expected=none", res_data);
                end else begin
                    e = sb.pop_front();
                    check("res_beat", {res_err, res_overflow, res_last, res_data}, e);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1; prev_data = res_data; prev_last = res_last;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'b000; cmd_scalar = 8'h00; cmd_size = 3'd0;
        ld_valid = 1'b0; ld_data = 40'h0; res_ready = 1'b1;
        alu_c_flat = 200'h0; alu_overflow = 1'b0; alu_hang = 1'b0;
        exp_a = 200'h0; exp_b = 200'h0; exp_f = 8'h00; exp_op = 3'b000; exp_act = 0;
        repeat (3) @(posedge clk); #1;
        check("reset_state", {busy, cmd_ready, ld_ready, res_valid, res_last, res_err, alu_opcode}, 9'h0);
        check("reset_alu_a", alu_a_flat, 200'h0);
        rst = 1'b0; #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Add, size 3; upper columns of the sent rows must be masked off.
        exp_a = 200'h0; exp_b = 200'h0;
        for (int r = 0; r < 3; r++) exp_a[r*40 +: 40] = 40'h00000E0E0E;
        exp_b[39:0] = 40'h0000030201;
        exp_op = 3'b001; exp_f = 8'h00; exp_act = 3;
        alu_c_flat = 200'h0;
        alu_c_flat[39:0] = 40'h000011100F; alu_c_flat[79:40] = 40'h00000E0E0E; alu_c_flat[119:80] = 40'h00000E0E0E;
        alu_overflow = 1'b0;
        push(40'h000011100F, 1'b0, 1'b0, 1'b0);
        push(40'h00000E0E0E, 1'b0, 1'b0, 1'b0);
        push(40'h00000E0E0E, 1'b1, 1'b0, 1'b0);
        send_cmd(3'b001, 8'h00, 3'd3);
        for (int r = 0; r < 3; r++) load_row(40'h0E0E0E0E0E);
        load_row(40'hFFFF030201); load_row(40'h0); load_row(40'h0);
        wait_frame();

        // Scalar x0A, size 5, no B phase; 14*10=140 overflows int8.
        exp_a = {25{8'h0E}}; exp_b = 200'h0; exp_op = 3'b110; exp_f = 8'h0A; exp_act = 3;
        alu_c_flat = {25{8'h8C}}; alu_overflow = 1'b1;
        for (int r = 0; r < 5; r++) push(40'h8C8C8C8C8C, r == 4, 1'b1, 1'b0);
        send_cmd(3'b110, 8'h0A, 3'd5);
        for (int r = 0; r < 5; r++) load_row(40'h0E0E0E0E0E);
        check("ld_ready_after_a", ld_ready, 1'b0);
        wait_frame();

        // Alu never answers: 16 WAIT cycles then a zero frame with res_err.
        alu_hang = 1'b1;
        exp_a = 200'h0; exp_a[39:0] = 40'h0000000102; exp_a[79:40] = 40'h0000000102;
        exp_b = 200'h0; exp_op = 3'b100; exp_f = 8'h55; exp_act = 17;
        alu_c_flat = {25{8'hFF}}; alu_overflow = 1'b1;
        push(40'h0, 1'b0, 1'b0, 1'b1);
        push(40'h0, 1'b1, 1'b0, 1'b1);
        send_cmd(3'b100, 8'h55, 3'd2);
        load_row(40'h0707070102); load_row(40'h0707070102);
        wait_frame();
        check("alu_op_idle_after_timeout", alu_opcode, 3'b000);
        alu_hang = 1'b0;

        // Illegal commands: opcode 000, then size 6.
        push(40'h0, 1'b1, 1'b0, 1'b1);
        send_cmd(3'b000, 8'h00, 3'd3);
        check("err_op0_no_ld", {ld_ready, busy}, 2'b01);
        wait_frame();
        push(40'h0, 1'b1, 1'b0, 1'b1);
        send_cmd(3'b001, 8'h00, 3'd6);
        check("err_size6_no_ld", {ld_ready, busy}, 2'b01);
        wait_frame();

        // Transpose, size 5, distinct rows; res_ready low for 3 cycles on row 1.
        exp_a = 200'h0; exp_b = 200'h0; exp_op = 3'b101; exp_f = 8'h00; exp_act = 3;
        alu_c_flat = 200'h0; alu_overflow = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                exp_a[(r*5+c)*8 +: 8] = 8'(r*16 + c);
                alu_c_flat[(r*5+c)*8 +: 8] = 8'(c*16 + r);
            end
        for (int r = 0; r < 5; r++) push(alu_c_flat[r*40 +: 40], r == 4, 1'b0, 1'b0);
        res_ready = 1'b0;
        send_cmd(3'b101, 8'h00, 3'd5);
        for (int r = 0; r < 5; r++) load_row(exp_a[r*40 +: 40]);
        for (int i = 0; i < 100 && !res_valid; i++) begin @(posedge clk); #1; end
        check("res_valid_seen", res_valid, 1'b1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        res_ready = 1'b1;
        wait_frame();

        // Reset during LOAD_B after 2 beats, then a clean add of size 2.
        send_cmd(3'b001, 8'h00, 3'd3);
        for (int r = 0; r < 3; r++) load_row(40'h0E0E0E0E0E);
        load_row(40'h0101010101); load_row(40'h0101010101);
        rst = 1'b1; #1;
        check("rst_mid_outputs", {busy, cmd_ready, ld_ready, res_valid, res_err, alu_opcode, alu_f}, 16'h0);
        check("rst_mid_alu_a", alu_a_flat, 200'h0);
        check("rst_mid_alu_b", alu_b_flat, 200'h0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("cmd_ready_after_rst", cmd_ready, 1'b1);
        @(posedge clk); #1;
        exp_a = 200'h0; exp_b = 200'h0;
        exp_a[39:0] = 40'h0000002121; exp_a[79:40] = 40'h0000002121;
        exp_b[39:0] = 40'h0000000101; exp_b[79:40] = 40'h0000000101;
        exp_op = 3'b001; exp_f = 8'h00; exp_act = 3;
        alu_c_flat = 200'h0; alu_c_flat[39:0] = 40'h0000002222; alu_c_flat[79:40] = 40'h0000002222;
        alu_overflow = 1'b0;
        push(40'h0000002222, 1'b0, 1'b0, 1'b0);
        push(40'h0000002222, 1'b1, 1'b0, 1'b0);
        send_cmd(3'b001, 8'h00, 3'd2);
        load_row(40'h2121212121); load_row(40'h2121212121);
        load_row(40'h0101010101); load_row(40'h0101010101);
        wait_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
